comb_dmem_bus: RTL and testbench

- Shared data-memory (DMEM) port for NCORES RISC-V cores: one single-port 32-bit RAM, combinational round-robin arbitration, per-core LR/SC reservations.
- Sits between each core's DMEM-range decode and the RAM.
- Grant/stall are combinational in the request cycle; read data returns one cycle after grant.

---
 rtl/comb_dmem_bus.sv | 203 ++++++++++++++++++++
 tb/tb_comb_dmem_bus.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/comb_dmem_bus.sv
// comb_dmem_bus: shared single-port data memory for NCORES cores.
// Combinational round-robin arbitration picks one request per cycle; granted
// reads return one cycle later through a per-core result slot. Each core owns
// one LR/SC reservation that is killed by any performed write to its word.
module comb_dmem_bus #(
   parameter int NCORES     = 4,
   parameter int DMEM_ADDRW = 12
) (
   input  logic                         clk_i,
   input  logic                         rst_ni,
   input  logic [NCORES-1:0]            re_packed_i,
   input  logic [NCORES-1:0]            we_packed_i,
   input  logic [DMEM_ADDRW*NCORES-1:0] addr_packed_i,
   input  logic [32*NCORES-1:0]         wdata_packed_i,
   input  logic [4*NCORES-1:0]          wstrb_packed_i,
   input  logic [NCORES-1:0]            is_lr_packed_i,
   input  logic [NCORES-1:0]            is_sc_packed_i,
   output logic [32*NCORES-1:0]         rdata_packed_o,
   output logic [NCORES-1:0]            stall_packed_o
);

   localparam int IDXW  = (NCORES > 1) ? $clog2(NCORES) : 1;
   localparam int DEPTH = 1 << DMEM_ADDRW;

   // ---------------------------------------------------------------------
   // Per-core views of the packed request buses
   // ---------------------------------------------------------------------
   logic [DMEM_ADDRW-1:0] addr_w  [NCORES];
   logic [31:0]           wdata_w [NCORES];
   logic [3:0]            wstrb_w [NCORES];
   logic [NCORES-1:0]     req_w;

   genvar gi;
   generate
      for (gi = 0; gi < NCORES; gi++) begin : g_unpack
         assign addr_w[gi]  = addr_packed_i[DMEM_ADDRW*gi +: DMEM_ADDRW];
         assign wdata_w[gi] = wdata_packed_i[32*gi +: 32];
         assign wstrb_w[gi] = wstrb_packed_i[4*gi +: 4];
         assign req_w[gi]   = re_packed_i[gi] | we_packed_i[gi];
      end
   endgenerate

   // ---------------------------------------------------------------------
   // State
   // ---------------------------------------------------------------------
   logic [IDXW-1:0]       ptr_q, ptr_d;          // round-robin search start
   logic                  rd_pend_q;             // a read was granted last cycle
   logic [IDXW-1:0]       rd_core_q;             // ...and which core it belongs to
   logic [31:0]           mem_rd_q;              // registered RAM read port
   logic [31:0]           slot_q      [NCORES];  // held result per core
   logic                  resv_valid_q[NCORES];
   logic [DMEM_ADDRW-1:0] resv_addr_q [NCORES];
   logic [31:0]           mem_q       [DEPTH];

   // ---------------------------------------------------------------------
   // Arbitration
   // ---------------------------------------------------------------------
   logic [NCORES-1:0] grant;
   logic              gnt_valid;
   logic [IDXW-1:0]   gnt_idx;

   // Search from ptr_q with wrap-around; no grant is ever issued in reset
   always_comb begin
      int              c;
      logic [IDXW-1:0] cidx;
      grant     = '0;
      gnt_valid = 1'b0;
      gnt_idx   = '0;
      c         = 0;
      cidx      = '0;
      if (rst_ni) begin
         for (int i = 0; i < NCORES; i++) begin
            c = int'(ptr_q) + i;
            if (c >= NCORES) begin
               c = c - NCORES;
            end
            cidx = IDXW'(c);
            if (!gnt_valid && req_w[cidx]) begin
               gnt_valid = 1'b1;
               gnt_idx   = cidx;
            end
         end
         if (gnt_valid) begin
            grant[gnt_idx] = 1'b1;
         end
      end
   end

   assign stall_packed_o = req_w & ~grant;

   // Pointer moves just past the winner so the winner gets lowest priority next
   always_comb begin
      ptr_d = ptr_q;
      if (gnt_valid) begin
         ptr_d = (int'(gnt_idx) == NCORES - 1) ? '0 : gnt_idx + 1'b1;
      end
   end

   // ---------------------------------------------------------------------
   // Granted access decode
   // ---------------------------------------------------------------------
   logic [DMEM_ADDRW-1:0] g_addr;
   logic [31:0]           g_wdata;
   logic [3:0]            g_wstrb;
   logic                  g_write;
   logic                  lr_done;
   logic                  sc_done;
   logic                  sc_ok;
   logic                  mem_we;
   logic                  mem_re;

   assign g_addr  = addr_w[gnt_idx];
   assign g_wdata = wdata_w[gnt_idx];
   assign g_wstrb = wstrb_w[gnt_idx];
   // re+we together is a write; LR flag only matters on a read, SC on a write
   assign g_write = we_packed_i[gnt_idx];
   assign lr_done = gnt_valid & ~g_write & is_lr_packed_i[gnt_idx];
   assign sc_done = gnt_valid &  g_write & is_sc_packed_i[gnt_idx];
   assign sc_ok   = resv_valid_q[gnt_idx] && (resv_addr_q[gnt_idx] == g_addr);
   // A failed SC is the only granted write that leaves the RAM untouched
   assign mem_we  = gnt_valid & g_write & (~sc_done | sc_ok);
   assign mem_re  = gnt_valid & ~g_write;

   // ---------------------------------------------------------------------
   // RAM
   // ---------------------------------------------------------------------
   // Byte-lane write and registered read, no reset so it maps onto block RAM
   always_ff @(posedge clk_i) begin
      if (mem_we) begin
         for (int j = 0; j < 4; j++) begin
            if (g_wstrb[j]) begin
               mem_q[g_addr][8*j +: 8] <= g_wdata[8*j +: 8];
            end
         end
      end
      if (mem_re) begin
         mem_rd_q <= mem_q[g_addr];
      end
   end

   // Pointer and read-return tracking
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         ptr_q     <= '0;
         rd_pend_q <= 1'b0;
         rd_core_q <= '0;
      end else begin
         ptr_q     <= ptr_d;
         rd_pend_q <= mem_re;
         rd_core_q <= gnt_idx;
      end
   end

   // Result slots: fresh RAM data is folded in the cycle after it is shown;
   // an SC result is written directly and overrides a fold for the same core
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int k = 0; k < NCORES; k++) begin
            slot_q[k] <= '0;
         end
      end else begin
         for (int k = 0; k < NCORES; k++) begin
            if (sc_done && (gnt_idx == IDXW'(k))) begin
               slot_q[k] <= {31'b0, ~sc_ok};
            end else if (rd_pend_q && (rd_core_q == IDXW'(k))) begin
               slot_q[k] <= mem_rd_q;
            end
         end
      end
   end

   // Reservations: set by LR, consumed by own SC, killed by any performed write
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int k = 0; k < NCORES; k++) begin
            resv_valid_q[k] <= 1'b0;
            resv_addr_q[k]  <= '0;
         end
      end else begin
         for (int k = 0; k < NCORES; k++) begin
            if (lr_done && (gnt_idx == IDXW'(k))) begin
               resv_valid_q[k] <= 1'b1;
               resv_addr_q[k]  <= g_addr;
            end else if (sc_done && (gnt_idx == IDXW'(k))) begin
               resv_valid_q[k] <= 1'b0;
            end else if (mem_we && resv_valid_q[k] && (resv_addr_q[k] == g_addr)) begin
               resv_valid_q[k] <= 1'b0;
            end
         end
      end
   end

   // ---------------------------------------------------------------------
   // Read data: show RAM output directly in the return cycle, else the slot
   // ---------------------------------------------------------------------
   generate
      for (gi = 0; gi < NCORES; gi++) begin : g_rdata
         assign rdata_packed_o[32*gi +: 32] =
            (rd_pend_q && (rd_core_q == IDXW'(gi))) ? mem_rd_q : slot_q[gi];
      end
   endgenerate

endmodule

// File: tb/tb_comb_dmem_bus.sv
// Testbench for comb_dmem_bus: directed table + hand sequences with constant
// expectations, plus randomized traffic checked against a behavioural model.
module tb_comb_dmem_bus;

   localparam int N  = 4;
   localparam int AW = 12;

   logic            clk   = 1'b0;
   logic            rst_n = 1'b1;
   logic [N-1:0]    re, we, is_lr, is_sc;
   logic [AW*N-1:0] addr;
   logic [32*N-1:0] wdata;
   logic [4*N-1:0]  wstrb;
   logic [32*N-1:0] rdata;
   logic [N-1:0]    stall;

   always #5 clk = ~clk;

   comb_dmem_bus #(.NCORES(N), .DMEM_ADDRW(AW)) dut (
      .clk_i          (clk),
      .rst_ni         (rst_n),
      .re_packed_i    (re),
      .we_packed_i    (we),
      .addr_packed_i  (addr),
      .wdata_packed_i (wdata),
      .wstrb_packed_i (wstrb),
      .is_lr_packed_i (is_lr),
      .is_sc_packed_i (is_sc),
      .rdata_packed_o (rdata),
      .stall_packed_o (stall)
   );

   int n_vec = 0;
   int n_err = 0;

   // Behavioural model state
   logic [31:0] m_mem [int];
   bit          m_rv  [N];
   logic [AW-1:0] m_ra [N];
   logic [31:0] m_rd  [N];
   int          m_ptr;
   logic [N-1:0] last_stall, last_exp_stall;

   typedef struct {
      logic [N-1:0] req;
      logic [N-1:0] exp_stall;
      int           core;
      logic [31:0]  exp_data;
   } vec_t;

   function automatic logic [31:0] init_val(int a);
      return 32'h5A00_0000 + 32'(a) * 32'h0001_0003;
   endfunction

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic set_core(int k, bit r, bit w, int a, logic [31:0] d, logic [3:0] s, bit lr, bit sc);
      re[k] = r;
      we[k] = w;
      addr[AW*k +: AW] = AW'(a);
      wdata[32*k +: 32] = d;
      wstrb[4*k +: 4] = s;
      is_lr[k] = lr;
      is_sc[k] = sc;
   endtask

   task automatic idle_core(int k);
      set_core(k, 1'b0, 1'b0, 0, 32'h0, 4'h0, 1'b0, 1'b0);
   endtask

   task automatic idle_all();
      for (int k = 0; k < N; k++) idle_core(k);
   endtask

   function automatic logic [31:0] m_read(int a);
      return m_mem.exists(a) ? m_mem[a] : 32'h0;
   endfunction

   task automatic model_reset();
      m_ptr = 0;
      for (int k = 0; k < N; k++) begin
         m_rv[k] = 1'b0;
         m_ra[k] = '0;
         m_rd[k] = '0;
      end
   endtask

   // Round-robin: first requester at or after the pointer, wrapping
   function automatic int model_pick();
      if (!rst_n) return -1;
      for (int i = 0; i < N; i++) begin
         int k = (m_ptr + i) % N;
         if (re[k] || we[k]) return k;
      end
      return -1;
   endfunction

   task automatic model_apply(int g);
      int a;
      bit perform;
      logic [31:0] nw;
      a = int'(addr[AW*g +: AW]);
      if (we[g]) begin
         perform = 1'b1;
         if (is_sc[g]) begin
            perform = m_rv[g] && (m_ra[g] == AW'(a));
            m_rv[g] = 1'b0;
            m_rd[g] = perform ? 32'd0 : 32'd1;
         end
         if (perform) begin
            nw = m_read(a);
            for (int j = 0; j < 4; j++)
               if (wstrb[4*g + j]) nw[8*j +: 8] = wdata[32*g + 8*j +: 8];
            m_mem[a] = nw;
            for (int c = 0; c < N; c++)
               if (m_rv[c] && (m_ra[c] == AW'(a))) m_rv[c] = 1'b0;
         end
      end else begin
         m_rd[g] = m_read(a);
         if (is_lr[g]) begin
            m_rv[g] = 1'b1;
            m_ra[g] = AW'(a);
         end
      end
      m_ptr = (g + 1) % N;
   endtask

   function automatic logic [32*N-1:0] model_packed();
      logic [32*N-1:0] v;
      for (int k = 0; k < N; k++) v[32*k +: 32] = m_rd[k];
      return v;
   endfunction

   // One bus cycle: check stall mid-cycle, clock, then check all result slots
   task automatic tick();
      int g;
      logic [N-1:0] exp_st;
      #2;
      g = model_pick();
      exp_st = re | we;
      if (g >= 0) exp_st[g] = 1'b0;
      chk("stall", 128'(stall), 128'(exp_st));
      last_stall     = stall;
      last_exp_stall = exp_st;
      @(posedge clk);
      #1;
      if (g >= 0) model_apply(g);
      chk("rdata", rdata, model_packed());
   endtask

   task automatic reset_pulse();
      rst_n = 1'b0;
      model_reset();
      tick();
      rst_n = 1'b1;
   endtask

   initial begin
      vec_t tbl[4];
      int kind, a;
      logic [31:0] d;
      logic [3:0] s;

      idle_all();
      model_reset();
      last_stall = '0;
      last_exp_stall = '0;
      #1 rst_n = 1'b0;
      @(posedge clk);
      #1;
      chk("reset_rdata", rdata, '0);
      chk("reset_stall", 128'(stall), '0);
      rst_n = 1'b1;

      // Known contents for the word range used by the tests
      for (int i = 0; i < 64; i++) begin
         set_core(0, 1'b0, 1'b1, i, init_val(i), 4'hF, 1'b0, 1'b0);
         tick();
      end
      idle_all();

      // Single read with hold
      set_core(0, 1'b0, 1'b1, 5, 32'hDEADBEEF, 4'hF, 1'b0, 1'b0);
      tick();
      set_core(0, 1'b1, 1'b0, 5, 32'h0, 4'h0, 1'b0, 1'b0);
      tick();
      chk("read_stall0", 128'(last_stall[0]), 128'(0));
      chk("read_data0", 128'(rdata[31:0]), 128'(32'hDEADBEEF));
      idle_all();
      tick();
      tick();
      chk("read_hold0", 128'(rdata[31:0]), 128'(32'hDEADBEEF));
      $display("single read: rdata0=0x%08h", rdata[31:0]);

      // Byte-strobed write
      set_core(1, 1'b0, 1'b1, 16, 32'hAAAAAAAA, 4'hF, 1'b0, 1'b0);
      tick();
      set_core(1, 1'b0, 1'b1, 16, 32'h11223344, 4'b0101, 1'b0, 1'b0);
      tick();
      set_core(1, 1'b1, 1'b0, 16, 32'h0, 4'h0, 1'b0, 1'b0);
      tick();
      chk("byte_write", 128'(rdata[63:32]), 128'(32'hAA22AA44));
      $display("byte write: rdata1=0x%08h", rdata[63:32]);
      idle_all();

      // Contention from ptr = 0: cores drop their request once granted
      tbl[0] = '{4'b1111, 4'b1110, 0, init_val(60)};
      tbl[1] = '{4'b1110, 4'b1100, 1, init_val(61)};
      tbl[2] = '{4'b1100, 4'b1000, 2, init_val(62)};
      tbl[3] = '{4'b1000, 4'b0000, 3, init_val(63)};
      reset_pulse();
      for (int r = 0; r < 4; r++) begin
         for (int k = 0; k < N; k++) begin
            if (tbl[r].req[k]) set_core(k, 1'b1, 1'b0, 60 + k, 32'h0, 4'h0, 1'b0, 1'b0);
            else idle_core(k);
         end
         tick();
         chk("contend_stall", 128'(last_stall), 128'(tbl[r].exp_stall));
         chk("contend_data", 128'(rdata[32*tbl[r].core +: 32]), 128'(tbl[r].exp_data));
         $display("contention row %0d: stall=%b rdata%0d=0x%08h", r, last_stall,
                  tbl[r].core, rdata[32*tbl[r].core +: 32]);
      end
      idle_all();

      // LR/SC success
      set_core(2, 1'b1, 1'b0, 32, 32'h0, 4'h0, 1'b1, 1'b0);
      tick();
      chk("lr_data2", 128'(rdata[95:64]), 128'(init_val(32)));
      set_core(2, 1'b0, 1'b1, 32, 32'h5, 4'hF, 1'b0, 1'b1);
      tick();
      chk("sc_ok2", 128'(rdata[95:64]), 128'(0));
      set_core(2, 1'b1, 1'b0, 32, 32'h0, 4'h0, 1'b0, 1'b0);
      tick();
      chk("sc_mem2", 128'(rdata[95:64]), 128'(5));
      $display("lr/sc success: RAM[0x20]=0x%08h", rdata[95:64]);
      idle_all();

      // LR/SC killed by another core's store
      set_core(0, 1'b1, 1'b0, 48, 32'h0, 4'h0, 1'b1, 1'b0);
      tick();
      idle_core(0);
      set_core(1, 1'b0, 1'b1, 48, 32'h77, 4'hF, 1'b0, 1'b0);
      tick();
      idle_core(1);
      set_core(0, 1'b0, 1'b1, 48, 32'h99, 4'hF, 1'b0, 1'b1);
      tick();
      chk("sc_kill0", 128'(rdata[31:0]), 128'(1));
      set_core(0, 1'b1, 1'b0, 48, 32'h0, 4'h0, 1'b0, 1'b0);
      tick();
      chk("sc_kill_mem", 128'(rdata[31:0]), 128'(32'h77));
      idle_core(0);
      set_core(3, 1'b0, 1'b1, 49, 32'h1234, 4'hF, 1'b0, 1'b1);
      tick();
      chk("sc_nolr3", 128'(rdata[127:96]), 128'(1));
      $display("lr/sc kill: rdata0=0x%08h sc-without-lr rdata3=0x%08h", rdata[31:0], rdata[127:96]);
      idle_all();

      // Reset while core 3 is stalled and core 2's read is in flight
      reset_pulse();
      set_core(1, 1'b1, 1'b0, 51, 32'h0, 4'h0, 1'b1, 1'b0);
      tick();
      idle_core(1);
      set_core(2, 1'b1, 1'b0, 52, 32'h0, 4'h0, 1'b0, 1'b0);
      set_core(3, 1'b1, 1'b0, 53, 32'h0, 4'h0, 1'b0, 1'b0);
      tick();
      chk("pre_rst_stall", 128'(last_stall), 128'(4'b1000));
      idle_core(2);
      rst_n = 1'b0;
      model_reset();
      #1;
      chk("rst_rdata", rdata, '0);
      chk("rst_stall", 128'(stall), 128'(4'b1000));
      tick();
      rst_n = 1'b1;
      tick();
      chk("post_rst_stall", 128'(last_stall), 128'(0));
      chk("post_rst_data3", 128'(rdata[127:96]), 128'(init_val(53)));
      idle_core(3);
      set_core(1, 1'b0, 1'b1, 51, 32'hABCD, 4'hF, 1'b0, 1'b1);
      tick();
      chk("post_rst_sc1", 128'(rdata[63:32]), 128'(1));
      $display("reset: core3 rdata=0x%08h, core1 SC result=%0d", rdata[127:96], rdata[63:32]);
      idle_all();

      // Randomized traffic on a few words to provoke SC/store races
      for (int cyc = 0; cyc < 400; cyc++) begin
         for (int k = 0; k < N; k++) begin
            if (!last_exp_stall[k]) begin
               kind = $urandom_range(0, 7);
               a    = $urandom_range(0, 7);
               d    = $urandom;
               s    = 4'($urandom_range(1, 15));
               case (kind)
                  0, 1: idle_core(k);
                  2: set_core(k, 1'b1, 1'b0, a, d, s, 1'b0, 1'b0);
                  3: set_core(k, 1'b1, 1'b0, a, d, s, 1'b1, 1'b0);
                  4: set_core(k, 1'b0, 1'b1, a, d, s, 1'b0, 1'b0);
                  5: set_core(k, 1'b0, 1'b1, a, d, s, 1'b0, 1'b1);
                  6: set_core(k, 1'b1, 1'b1, a, d, s, 1'($urandom), 1'($urandom));
                  default: set_core(k, 1'b1, 1'b0, a, d, s, 1'b0, 1'b1);
               endcase
            end
         end
         if (cyc == 200) begin
            rst_n = 1'b0;
            model_reset();
            tick();
            rst_n = 1'b1;
         end else begin
            tick();
         end
      end
      idle_all();
      tick();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
